// File: rtl/regs_dbg_access_ctrl_pkg.sv
// Shared encodings and default sizing for the debug register-access sequencer.
// State encodings and the default starvation limit live here so all users agree.
package regs_dbg_access_ctrl_pkg;

    localparam int DBG_ADDR_W     = 5;
    localparam int DBG_DATA_W     = 32;
    localparam int DBG_STARVE_MAX = 8;

    typedef enum logic [1:0] {
        DBG_ST_IDLE = 2'd0,
        DBG_ST_WAIT = 2'd1,
        DBG_ST_RESP = 2'd2
    } dbg_state_t;

endpackage

// File: rtl/regs_dbg_access_ctrl_if.sv
// Debug-module side of the register access path: request (req/gnt) and response (valid/ready).
// master = debug module, slave = regs_dbg_access_ctrl.
interface regs_dbg_access_ctrl_if
    import regs_dbg_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = DBG_ADDR_W,
    parameter int DATA_W = DBG_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rdata;
    logic              rsp_err;

    modport master (
        output req, we, addr, wdata, rsp_ready,
        input  gnt, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  req, we, addr, wdata, rsp_ready,
        output gnt, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/regs_dbg_access_ctrl.sv
// Sequences one buffered debug register request onto the regfile jtag port, yielding to core writeback.
// Latency: >=1 cycle grant->rsp_valid; starving requests raise core_hold_o; response held until ready.
module regs_dbg_access_ctrl
    import regs_dbg_access_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DBG_ADDR_W,
    parameter int DATA_W     = DBG_DATA_W,
    parameter int STARVE_MAX = DBG_STARVE_MAX
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_wr_en_i,
    input  logic [ADDR_W-1:0]       core_wr_addr_i,
    output logic                    core_hold_o,
    regs_dbg_access_ctrl_if.slave   dbg,
    output logic                    rf_jtag_we_o,
    output logic [ADDR_W-1:0]       rf_jtag_addr_o,
    output logic [DATA_W-1:0]       rf_jtag_data_o,
    input  logic [DATA_W-1:0]       rf_jtag_data_i
);

    localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    dbg_state_t        state;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [CNT_W-1:0]  starve_cnt;
    logic              core_hold;

    logic              buf_addr_zero;
    logic              core_wr_live;
    logic              slot_free;
    logic [CNT_W-1:0]  starve_nxt;

    // x0 never touches the write port, so it is always free; a write conflicts with any
    // live core write, a read only with a core write to the same register.
    always_comb begin
        buf_addr_zero = (buf_addr == '0);
        core_wr_live  = core_wr_en_i && (core_wr_addr_i != '0);
        slot_free     = buf_addr_zero ||
                        (buf_we ? !core_wr_live
                                : !(core_wr_live && (core_wr_addr_i == buf_addr)));
        starve_nxt    = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
    end

    assign dbg.gnt        = (state == DBG_ST_IDLE);
    assign dbg.rsp_valid  = (state == DBG_ST_RESP);
    assign dbg.rdata      = rsp_rdata;
    assign dbg.rsp_err    = rsp_err;
    assign core_hold_o    = core_hold;
    assign rf_jtag_we_o   = (state == DBG_ST_WAIT) && slot_free && buf_we && !buf_addr_zero;
    assign rf_jtag_addr_o = buf_addr;
    assign rf_jtag_data_o = buf_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= DBG_ST_IDLE;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            starve_cnt <= '0;
            core_hold  <= 1'b0;
        end else begin
            case (state)
                DBG_ST_IDLE: begin
                    if (dbg.req) begin
                        buf_we     <= dbg.we;
                        buf_addr   <= dbg.addr;
                        buf_wdata  <= dbg.wdata;
                        starve_cnt <= '0;
                        state      <= DBG_ST_WAIT;
                    end
                end
                DBG_ST_WAIT: begin
                    if (slot_free) begin
                        rsp_rdata <= buf_we ? '0 : rf_jtag_data_i;
                        rsp_err   <= buf_we && buf_addr_zero;
                        core_hold <= 1'b0;
                        state     <= DBG_ST_RESP;
                    end else begin
                        starve_cnt <= starve_nxt;
                        if (starve_nxt == STARVE_LIM) begin
                            core_hold <= 1'b1;
                        end
                    end
                end
                DBG_ST_RESP: begin
                    // Response regs return to zero so idle outputs stay quiet.
                    if (dbg.rsp_ready) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= DBG_ST_IDLE;
                    end
                end
                default: state <= DBG_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regs_dbg_access_ctrl.sv
// Bench for regs_dbg_access_ctrl: vector table, multi-cycle corner sequences, random traffic vs model.
// A small regfile with core-write priority sits on the jtag port.
module tb_regs_dbg_access_ctrl;

    localparam int SMAX = 8;

    logic        clk;
    logic        rst_n;
    logic        env_init;
    logic        core_wr_en;
    logic [4:0]  core_wr_addr;
    logic [31:0] core_wr_data;
    logic        core_hold;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic [31:0] mem [32];

    regs_dbg_access_ctrl_if #(.ADDR_W(5), .DATA_W(32)) dbg ();

    regs_dbg_access_ctrl #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_wr_en_i   (core_wr_en),
        .core_wr_addr_i (core_wr_addr),
        .core_hold_o    (core_hold),
        .dbg            (dbg),
        .rf_jtag_we_o   (rf_we),
        .rf_jtag_addr_o (rf_addr),
        .rf_jtag_data_o (rf_wdata),
        .rf_jtag_data_i (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rdata = (rf_addr == 5'd0) ? 32'h0 : mem[rf_addr];

    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
        end else if (core_wr_en && core_wr_addr != 5'd0) begin
            mem[core_wr_addr] <= core_wr_data;
        end else if (rf_we) begin
            mem[rf_addr] <= rf_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level reference: one pending request, one pending response, blocked-cycle count.
    bit          m_on = 0;
    bit          m_pend, m_resp, m_hold;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    bit          m_err;
    int          m_blk;

    logic        o_gnt, o_valid, o_hold, o_rfwe, o_err;
    logic [31:0] o_rdata;

    function automatic bit free_rule(bit we, logic [4:0] addr, logic cen, logic [4:0] caddr);
        if (addr == 5'd0) return 1'b1;
        if (we) return !(cen && caddr != 5'd0);
        return !(cen && caddr == addr);
    endfunction

    task automatic tick();
        bit free;
        @(negedge clk);
        o_gnt   = dbg.gnt;
        o_valid = dbg.rsp_valid;
        o_hold  = core_hold;
        o_rfwe  = rf_we;
        o_rdata = dbg.rdata;
        o_err   = dbg.rsp_err;
        free = free_rule(m_we, m_addr, core_wr_en, core_wr_addr);
        if (m_on) begin
            chk("gnt", o_gnt, !m_pend && !m_resp);
            chk("rsp_valid", o_valid, m_resp);
            chk("core_hold", o_hold, m_hold);
            chk("rf_jtag_we", o_rfwe, m_pend && free && m_we && m_addr != 5'd0);
            if (m_pend && free && m_we && m_addr != 5'd0) begin
                chk("rf_jtag_addr", rf_addr, m_addr);
                chk("rf_jtag_data", rf_wdata, m_wdata);
            end
            if (m_resp) begin
                chk("rsp_rdata", o_rdata, m_rdata);
                chk("rsp_err", o_err, m_err);
            end
        end
        if (!rst_n) begin
            m_on = 1; m_pend = 0; m_resp = 0; m_hold = 0; m_blk = 0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 0;
        end else if (m_on) begin
            if (!m_pend && !m_resp) begin
                if (dbg.req) begin
                    m_pend = 1; m_we = dbg.we; m_addr = dbg.addr; m_wdata = dbg.wdata; m_blk = 0;
                end
            end else if (m_pend) begin
                if (free) begin
                    m_pend = 0; m_resp = 1; m_hold = 0;
                    m_rdata = (m_we || m_addr == 5'd0) ? 32'h0 : mem[m_addr];
                    m_err = m_we && (m_addr == 5'd0);
                end else begin
                    if (m_blk < SMAX) m_blk++;
                    if (m_blk >= SMAX) m_hold = 1;
                end
            end else if (dbg.rsp_ready) begin
                m_resp = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          core_cyc;
        logic [4:0]  core_addr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wait;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, pulses, hold_k, rfwe_k, k;
        bit got, seen;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        1'b0, 0};
        vecs[1] = '{1'b0, 5'd5, 32'h0,        0, 5'd0, 32'hDEADBEEF, 1'b0, 0};
        vecs[2] = '{1'b1, 5'd0, 32'h55,       0, 5'd0, 32'h0,        1'b1, 0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1'b0, 0};
        vecs[4] = '{1'b0, 5'd3, 32'h0,        4, 5'd3, 32'h103,      1'b0, 4};
        vecs[5] = '{1'b0, 5'd9, 32'h0,        4, 5'd3, 32'h1009,     1'b0, 0};
        vecs[6] = '{1'b1, 5'd7, 32'h1,        3, 5'd4, 32'h0,        1'b0, 3};
        vecs[7] = '{1'b0, 5'd7, 32'h0,        0, 5'd0, 32'h1,        1'b0, 0};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        2, 5'd0, 32'h0,        1'b0, 0};

        env_init = 1; rst_n = 0;
        core_wr_en = 0; core_wr_addr = '0; core_wr_data = '0;
        dbg.req = 0; dbg.we = 0; dbg.addr = '0; dbg.wdata = '0; dbg.rsp_ready = 0;
        #1;
        tick();
        tick();
        env_init = 0; rst_n = 1;
        tick();
        chk("reset_gnt", o_gnt, 1'b1);
        chk("reset_hold", o_hold, 1'b0);
        chk("reset_valid", o_valid, 1'b0);
        chk("reset_rfwe", o_rfwe, 1'b0);
        chk("reset_rdata", o_rdata, 32'h0);

        for (int v = 0; v < 9; v++) begin
            dbg.req = 1; dbg.we = vecs[v].we; dbg.addr = vecs[v].addr; dbg.wdata = vecs[v].wdata;
            core_wr_en = 0;
            tick();
            dbg.req = 0;
            lat = 0; pulses = 0; got = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                core_wr_en   = (c < vecs[v].core_cyc);
                core_wr_addr = vecs[v].core_addr;
                core_wr_data = 32'h100 + c;
                tick();
                if (o_rfwe) pulses++;
                if (o_valid) got = 1; else lat++;
            end
            chk($sformatf("vec%0d_timeout", v), got, 1'b1);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_wait + 1);
            chk($sformatf("vec%0d_rfwe_pulses", v), pulses, (vecs[v].we && vecs[v].addr != 5'd0) ? 1 : 0);
            chk($sformatf("vec%0d_rdata", v), o_rdata, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_err", v), o_err, vecs[v].exp_err);
            core_wr_en = 0; dbg.rsp_ready = 1;
            tick();
            dbg.rsp_ready = 0;
            if (vecs[v].we && vecs[v].addr != 5'd0)
                chk($sformatf("vec%0d_regfile", v), mem[vecs[v].addr], vecs[v].wdata);
        end

        // Starvation: core writes x12 until it sees the hold, then backs off.
        dbg.req = 1; dbg.we = 1; dbg.addr = 5'd7; dbg.wdata = 32'h1;
        tick();
        dbg.req = 0;
        hold_k = -1; rfwe_k = -1; k = 0; got = 0;
        while (k < 40 && !got) begin
            core_wr_en = !core_hold; core_wr_addr = 5'd12; core_wr_data = 32'hC0DE0000 + k;
            tick();
            if (o_hold && hold_k < 0) hold_k = k;
            if (o_rfwe) rfwe_k = k;
            if (o_valid) got = 1;
            k++;
        end
        chk("starve_first_hold_cycle", hold_k, SMAX);
        chk("starve_issue_cycle", rfwe_k, SMAX);
        chk("starve_hold_dropped", o_hold, 1'b0);
        chk("starve_err", o_err, 1'b0);
        core_wr_en = 0; dbg.rsp_ready = 1;
        tick();
        dbg.rsp_ready = 0;

        // Back-pressure: response held 5 cycles while a second request waits.
        dbg.req = 1; dbg.we = 0; dbg.addr = 5'd5;
        tick();
        dbg.addr = 5'd7;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid", o_valid, 1'b1);
            chk("bp_rdata", o_rdata, 32'hDEADBEEF);
            chk("bp_gnt", o_gnt, 1'b0);
        end
        dbg.rsp_ready = 1;
        tick();
        dbg.rsp_ready = 0;
        tick();
        chk("bp_second_gnt", o_gnt, 1'b1);
        dbg.req = 0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            got = o_valid;
        end
        chk("bp_second_valid", got, 1'b1);
        chk("bp_second_rdata", o_rdata, 32'h1);
        dbg.rsp_ready = 1;
        tick();
        dbg.rsp_ready = 0;

        // Reset while starved and holding: request must vanish without a write or response.
        dbg.req = 1; dbg.we = 1; dbg.addr = 5'd9; dbg.wdata = 32'hABCD;
        tick();
        dbg.req = 0;
        core_wr_en = 1; core_wr_addr = 5'd12; core_wr_data = 32'h77;
        seen = 0;
        for (int c = 0; c < 20 && !o_hold; c++) begin
            tick();
            if (o_rfwe) seen = 1;
        end
        chk("rst_seq_hold_raised", o_hold, 1'b1);
        rst_n = 0;
        tick();
        if (o_rfwe) seen = 1;
        rst_n = 1; core_wr_en = 0;
        tick();
        chk("rst_seq_gnt", o_gnt, 1'b1);
        chk("rst_seq_hold", o_hold, 1'b0);
        chk("rst_seq_valid", o_valid, 1'b0);
        if (o_rfwe) seen = 1;
        tick();
        tick();
        chk("rst_seq_no_rsp", o_valid, 1'b0);
        chk("rst_seq_no_rfwe", seen, 1'b0);
        chk("rst_seq_regfile", mem[9], 32'h1009);

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            dbg.req       = ($urandom % 3) == 0;
            dbg.we        = $urandom % 2;
            dbg.addr      = 5'($urandom % 8);
            dbg.wdata     = $urandom;
            core_wr_en    = core_hold ? (($urandom % 4) == 0) : ($urandom % 2);
            core_wr_addr  = 5'($urandom % 8);
            core_wr_data  = $urandom;
            dbg.rsp_ready = $urandom % 2;
            tick();
        end
        dbg.req = 0; core_wr_en = 0; dbg.rsp_ready = 1;
        for (int c = 0; c < 4; c++) tick();
        chk("final_idle_gnt", o_gnt, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
